// File: rtl/xm_mem_responder.sv
// Word-organised RAM responder for the XMakina core bus; access completes WAIT_STATES+1 cycles after accept.
// No queueing: memEn_i is ignored while memBusy_o is high, so the core must wait for busy to fall.
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] addr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic [WORD-1:0] rdData_o,
  output logic            memBusy_o,
  output logic            alignErr_o
);

  localparam logic       ST_IDLE   = 1'b0;
  localparam logic       ST_WAIT   = 1'b1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic                  state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2:0]   addr_q;
  logic                  rw_q;
  logic                  byte_q;
  logic [WORD-1:0]       wr_q;
  logic [WORD-1:0]       mem [0:(1<<DEPTH_LOG2)-1];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  done;
  logic [WORD-1:0]       rd_word;
  logic [7:0]            rd_byte;
  logic                  unused_addr_hi;

  // Upper address bits are dropped on purpose, so addresses alias across the RAM.
  assign unused_addr_hi = ^addr_i[WORD-1:DEPTH_LOG2+1];

  assign idx     = addr_q[DEPTH_LOG2:1];
  assign done    = (state == ST_WAIT) && (cnt == 4'd0);
  assign rd_word = mem[idx];
  assign rd_byte = addr_q[0] ? rd_word[15:8] : rd_word[7:0];

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      memBusy_o  <= 1'b0;
      alignErr_o <= 1'b0;
      rdData_o   <= '0;
    end else begin
      alignErr_o <= 1'b0;
      if (state == ST_IDLE) begin
        if (memEn_i) begin
          addr_q    <= addr_i[DEPTH_LOG2:0];
          rw_q      <= memRW_i;
          byte_q    <= byteOp_i;
          wr_q      <= wrData_i;
          cnt       <= WAIT_INIT;
          memBusy_o <= 1'b1;
          state     <= ST_WAIT;
        end
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        memBusy_o  <= 1'b0;
        state      <= ST_IDLE;
        alignErr_o <= ~byte_q & addr_q[0];
        if (!rw_q) begin
          rdData_o <= byte_q ? {{(WORD-8){1'b0}}, rd_byte} : rd_word;
        end
      end
    end
  end

  // Reset on the completion edge drops the pending write.
  always_ff @(posedge clk_i) begin
    if (!arst_i && done && rw_q) begin
      if (!byte_q) begin
        mem[idx] <= wr_q;
      end else if (addr_q[0]) begin
        mem[idx][15:8] <= wr_q[7:0];
      end else begin
        mem[idx][7:0] <= wr_q[7:0];
      end
    end
  end

endmodule
